// File: rtl/frame_pkg.sv
// Shared types and frame layout for the host frame receiver.
// Frame length depends on FRAME_CHECKSUM_EN (adds a trailing XOR byte when defined).
package frame_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDeliver = 2'd2,
    StFull    = 2'd3
  } state_e;

  // Control byte plus four data bytes held in the shadow buffer.
  localparam int unsigned PAYLOAD_LEN = 5;

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 6;
`else
  localparam int unsigned FRAME_LEN = 5;
`endif

  localparam int unsigned CTRL_IDX  = 0;
  localparam int unsigned DATA_IDX0 = 1;

  function automatic logic [7:0] xor_bytes(input logic [PAYLOAD_LEN*8-1:0] bytes);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < int'(PAYLOAD_LEN); i++) begin
      acc = acc ^ bytes[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Saturating inter-byte gap counter; expired when the count reaches GAP_TIMEOUT.
// GAP_TIMEOUT = 0 disables expiry entirely.
module frame_gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT);

  logic [GAP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != GAP_MAX)) begin
      count_d = count_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (GAP_TIMEOUT != 0) && (count_q == GAP_MAX);

endmodule

// File: rtl/host_frame_receiver.sv
// Assembles UART bytes into a command frame and hands it over via dataReceived/clearDR.
// Define FRAME_CHECKSUM_EN to append and verify a trailing XOR checksum byte.
module host_frame_receiver
  import frame_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 1_000_000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        clearDR,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  output logic        busy,
  output logic        overrun,
  output logic        frameError
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shadow_q [PAYLOAD_LEN];
  logic [PAYLOAD_LEN*8-1:0] frame_flat;
  logic        store;
  logic        load_out;
  logic        dr_d;
  logic        overrun_d;
  logic        frame_error_d;
  logic        gap_clear;
  logic        gap_expired;

  assign frame_flat = {shadow_q[4], shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[CTRL_IDX]};
  assign gap_clear  = (state_q != StCollect) || rxValid;
  assign busy       = (state_q == StCollect);

  frame_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk    (masterClock),
    .rst_n  (reset),
    .clear  (gap_clear),
    .enable (state_q == StCollect),
    .expired(gap_expired)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    store         = 1'b0;
    load_out      = 1'b0;
    dr_d          = dataReceived;
    overrun_d     = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // idx_q is always CTRL_IDX here, so the store lands in byte 0.
        if (rxValid) begin
          store   = 1'b1;
          idx_d   = 3'(DATA_IDX0);
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (rxValid) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            idx_d = 3'(CTRL_IDX);
`ifdef FRAME_CHECKSUM_EN
            if (rxByte == xor_bytes(frame_flat)) begin
              state_d = StDeliver;
            end else begin
              frame_error_d = 1'b1;
              state_d       = StIdle;
            end
`else
            store   = 1'b1;
            state_d = StDeliver;
`endif
          end else begin
            store = 1'b1;
            idx_d = idx_q + 3'd1;
          end
        end else if (gap_expired) begin
          frame_error_d = 1'b1;
          idx_d         = 3'(CTRL_IDX);
          state_d       = StIdle;
        end
      end
      StDeliver: begin
        overrun_d = rxValid;
        if (!clearDR) begin
          dr_d     = 1'b1;
          load_out = 1'b1;
          state_d  = StFull;
        end
      end
      StFull: begin
        overrun_d = rxValid;
        if (clearDR) begin
          dr_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int i = 0; i < int'(PAYLOAD_LEN); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (store) begin
        shadow_q[idx_q] <= rxByte;
      end
    end
  end

  // Outputs only change on entry to FULL so the consumer never sees a partial frame.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      dataReceived <= 1'b0;
      control      <= '0;
      inputData    <= '0;
      overrun      <= 1'b0;
      frameError   <= 1'b0;
    end else begin
      dataReceived <= dr_d;
      overrun      <= overrun_d;
      frameError   <= frame_error_d;
      if (load_out) begin
        control   <= frame_flat[7:0];
        inputData <= frame_flat[39:8];
      end
    end
  end

endmodule

// File: tb/tb_host_frame_receiver.sv
// Directed self-checking bench for host_frame_receiver (GAP_TIMEOUT = 16).
// Adds the checksum scenarios when FRAME_CHECKSUM_EN is defined.
module tb_host_frame_receiver;

  logic        masterClock = 1'b0;
  logic        reset;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        clearDR;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        busy;
  logic        overrun;
  logic        frameError;

  int checks = 0;
  int errors = 0;

  host_frame_receiver #(
    .GAP_TIMEOUT(16)
  ) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .rxValid     (rxValid),
    .rxByte      (rxByte),
    .clearDR     (clearDR),
    .dataReceived(dataReceived),
    .control     (control),
    .inputData   (inputData),
    .busy        (busy),
    .overrun     (overrun),
    .frameError  (frameError)
  );

  always #5 masterClock = ~masterClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxValid = 1'b1;
    rxByte  = b;
    tick();
    rxValid = 1'b0;
    rxByte  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] ctrl, input logic [31:0] data, input int gap);
    logic [7:0] sum;
    sum = ctrl ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
    send_byte(ctrl);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) tick();
      send_byte(data[i*8 +: 8]);
    end
`ifdef FRAME_CHECKSUM_EN
    for (int g = 0; g < gap; g++) tick();
    send_byte(sum);
`else
    if (sum == 8'h00) begin
      // sum is only transmitted in checksum builds
    end
`endif
  endtask

  task automatic release_frame();
    clearDR = 1'b1;
    tick();
    clearDR = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    rxValid = 1'b0;
    rxByte  = 8'h00;
    clearDR = 1'b0;
    tick();
    tick();
    check("rst_dr", {31'd0, dataReceived}, 32'd0);
    check("rst_ctrl", {24'd0, control}, 32'd0);
    check("rst_data", inputData, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_ferr", {31'd0, frameError}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: spaced frame, latency of two cycles from the last byte
    send_byte(8'h05);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    send_byte(8'h11); tick();
    send_byte(8'h22); tick();
    send_byte(8'h33); tick();
`ifdef FRAME_CHECKSUM_EN
    send_byte(8'h44); tick();
    send_byte(8'h05 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`else
    send_byte(8'h44);
`endif
    check("t1_dr_early", {31'd0, dataReceived}, 32'd0);
    check("t1_ctrl_early", {24'd0, control}, 32'd0);
    tick();
    check("t1_dr", {31'd0, dataReceived}, 32'd1);
    check("t1_ctrl", {24'd0, control}, 32'h05);
    check("t1_data", inputData, 32'h44332211);
    check("t1_busy_done", {31'd0, busy}, 32'd0);

    // 2: byte during a held frame is dropped
    send_byte(8'hAA);
    check("t2_ovr", {31'd0, overrun}, 32'd1);
    check("t2_ferr", {31'd0, frameError}, 32'd0);
    tick();
    check("t2_ovr_pulse", {31'd0, overrun}, 32'd0);
    check("t2_ctrl", {24'd0, control}, 32'h05);
    check("t2_data", inputData, 32'h44332211);
    check("t2_dr_held", {31'd0, dataReceived}, 32'd1);
    release_frame();
    check("t2_dr_clr", {31'd0, dataReceived}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // 3: gap timeout after 3 bytes, then a good frame
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    for (int i = 0; i < 16; i++) tick();
    check("t3_no_ferr_yet", {31'd0, frameError}, 32'd0);
    check("t3_busy_yet", {31'd0, busy}, 32'd1);
    tick();
    check("t3_ferr", {31'd0, frameError}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_ovr", {31'd0, overrun}, 32'd0);
    tick();
    check("t3_ferr_pulse", {31'd0, frameError}, 32'd0);
    send_frame(8'hA0, 32'hE4D3C2B1, 0);
    tick();
    check("t3_dr", {31'd0, dataReceived}, 32'd1);
    check("t3_ctrl", {24'd0, control}, 32'hA0);
    check("t3_data", inputData, 32'hE4D3C2B1);
    release_frame();

    // 4: clearDR still high when the last byte lands
    clearDR = 1'b1;
    send_frame(8'h5A, 32'h0F1E2D3C, 0);
    tick(); tick(); tick();
    check("t4_dr_wait", {31'd0, dataReceived}, 32'd0);
    check("t4_ctrl_wait", {24'd0, control}, 32'hA0);
    clearDR = 1'b0;
    tick();
    check("t4_dr", {31'd0, dataReceived}, 32'd1);
    check("t4_ctrl", {24'd0, control}, 32'h5A);
    check("t4_data", inputData, 32'h0F1E2D3C);
    release_frame();

    // 5: asynchronous reset in mid-frame
    send_byte(8'h77);
    send_byte(8'h88);
    #2;
    reset = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ctrl", {24'd0, control}, 32'd0);
    check("t5_data", inputData, 32'd0);
    check("t5_dr", {31'd0, dataReceived}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    send_frame(8'h3C, 32'h87654321, 1);
    tick();
    check("t5_dr_after", {31'd0, dataReceived}, 32'd1);
    check("t5_ctrl_after", {24'd0, control}, 32'h3C);
    check("t5_data_after", inputData, 32'h87654321);
    release_frame();

`ifdef FRAME_CHECKSUM_EN
    // 6: checksum accept and reject
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h01);
    tick();
    check("t6_dr_good", {31'd0, dataReceived}, 32'd1);
    check("t6_ctrl_good", {24'd0, control}, 32'h01);
    check("t6_data_good", inputData, 32'h05040302);
    release_frame();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h00);
    check("t6_ferr", {31'd0, frameError}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t6_dr_bad", {31'd0, dataReceived}, 32'd0);
    tick();
    check("t6_dr_bad2", {31'd0, dataReceived}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
